// File: rtl/axi_rd_arbiter_pkg.sv
// Shared definitions for the AXI read arbiter: FSM states and fixed AR attributes.
package a_defines;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } rd_state_e;

  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // AXI encodes burst length as beats minus one.
  function automatic logic [7:0] axi_len(input logic [7:0] words);
    return words - 8'd1;
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// Requester and AXI read-channel bundle; slave = arbiter view, master = environment view.
interface axi_rd_arbiter_if #(
  parameter int unsigned NUM_REQ = 2
);
  logic                       flush_i;
  logic [NUM_REQ-1:0]         req_valid_i;
  logic [NUM_REQ-1:0][31:0]   req_addr_i;
  logic [NUM_REQ-1:0][7:0]    req_len_i;
  logic [NUM_REQ-1:0]         req_ready_o;
  logic [NUM_REQ-1:0]         req_data_valid_o;
  logic [31:0]                req_data_o;
  logic                       bus_err_o;

  logic                       arvalid_o;
  logic                       arready_i;
  logic [31:0]                araddr_o;
  logic [7:0]                 arlen_o;
  logic [2:0]                 arsize_o;
  logic [1:0]                 arburst_o;

  logic                       rvalid_i;
  logic                       rready_o;
  logic [31:0]                rdata_i;
  logic [1:0]                 rresp_i;
  logic                       rlast_i;

  modport slave (
    input  flush_i, req_valid_i, req_addr_i, req_len_i,
    output req_ready_o, req_data_valid_o, req_data_o, bus_err_o,
    output arvalid_o, araddr_o, arlen_o, arsize_o, arburst_o,
    input  arready_i,
    input  rvalid_i, rdata_i, rresp_i, rlast_i,
    output rready_o
  );

  modport master (
    output flush_i, req_valid_i, req_addr_i, req_len_i,
    input  req_ready_o, req_data_valid_o, req_data_o, bus_err_o,
    input  arvalid_o, araddr_o, arlen_o, arsize_o, arburst_o,
    output arready_i,
    output rvalid_i, rdata_i, rresp_i, rlast_i,
    input  rready_o
  );

endinterface

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-way round-robin selector: the pointer names the port with priority this cycle.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    if (req_i[ptr_i]) begin
      gnt_o[ptr_i] = 1'b1;
    end else if (req_i[~ptr_i]) begin
      gnt_o[~ptr_i] = 1'b1;
    end
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-port AXI4 read arbiter: round-robin grant, one outstanding burst,
// zero-latency beat forwarding with flush drain and error reporting.
module axi_rd_arbiter
  import a_defines::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input logic             clk,
  input logic             rst_n,
  axi_rd_arbiter_if.slave bus
);

  rd_state_e          state_q, state_d;
  logic               ptr_q, ptr_d;
  logic               owner_q, owner_d;
  logic               drain_q, drain_d;
  logic [31:0]        addr_q, addr_d;
  logic [7:0]         len_q, len_d;
  logic [7:0]         beat_q, beat_d;

  logic [NUM_REQ-1:0] req_vec;
  logic [1:0]         gnt;
  logic               gnt_idx;
  logic [8:0]         beat_nxt;

  logic [NUM_REQ-1:0] ready;
  logic [NUM_REQ-1:0] dvalid;
  logic [31:0]        rdata_fwd;
  logic               err;
  logic               arvalid;
  logic               rready;

  // Grants only happen in IDLE, outside reset and outside a flush cycle.
  assign req_vec = (rst_n && (state_q == ST_IDLE) && !bus.flush_i) ? bus.req_valid_i : '0;

  rr_arb2 u_rr_arb2 (
    .req_i (req_vec),
    .ptr_i (ptr_q),
    .gnt_o (gnt)
  );

  assign gnt_idx  = gnt[1];
  assign beat_nxt = {1'b0, beat_q} + 9'd1;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    drain_d   = drain_q;
    addr_d    = addr_q;
    len_d     = len_q;
    beat_d    = beat_q;
    ready     = '0;
    dvalid    = '0;
    rdata_fwd = '0;
    err       = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          owner_d = gnt_idx;
          addr_d  = bus.req_addr_i[gnt_idx];
          len_d   = bus.req_len_i[gnt_idx];
          ptr_d   = ~gnt_idx;
          // Zero-length requests complete at the grant without touching AXI.
          if (bus.req_len_i[gnt_idx] == 8'd0) begin
            ready[gnt_idx] = 1'b1;
          end else begin
            state_d = ST_ADDR;
          end
        end
      end

      ST_ADDR: begin
        arvalid = 1'b1;
        if (bus.flush_i) begin
          drain_d = 1'b1;
        end
        if (bus.arready_i) begin
          ready[owner_q] = 1'b1;
          beat_d         = '0;
          state_d        = ST_DATA;
        end
      end

      ST_DATA: begin
        rready = 1'b1;
        if (bus.flush_i) begin
          drain_d = 1'b1;
        end
        if (bus.rvalid_i) begin
          beat_d    = beat_nxt[7:0];
          rdata_fwd = bus.rdata_i;
          if (!(bus.flush_i || drain_q)) begin
            dvalid[owner_q] = 1'b1;
          end
          err = bus.rresp_i[1];
          if (bus.rlast_i) begin
            // Nine-bit compare so a 256th beat is not aliased onto len 0.
            if (beat_nxt != {1'b0, len_q}) begin
              err = 1'b1;
            end
            drain_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      drain_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      drain_q <= drain_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
    end
  end

  assign bus.req_ready_o      = ready;
  assign bus.req_data_valid_o = dvalid;
  assign bus.req_data_o       = rdata_fwd;
  assign bus.bus_err_o        = err;
  assign bus.arvalid_o        = arvalid;
  assign bus.araddr_o         = addr_q;
  assign bus.arlen_o          = axi_len(len_q);
  assign bus.arsize_o         = AXI_SIZE_WORD;
  assign bus.arburst_o        = AXI_BURST_INCR;
  assign bus.rready_o         = rready;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Scoreboard bench for axi_rd_arbiter: a driver predicts grants, AR beats and
// forwarded words; an AXI slave model serves bursts; a monitor checks outputs.
module tb_axi_rd_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_rd_arbiter_if #(.NUM_REQ(2)) bus ();

  axi_rd_arbiter #(.NUM_REQ(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic flush_drv = 1'b0;
  logic flush_slv = 1'b0;
  assign bus.flush_i = flush_drv | flush_slv;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    int          nbeats;
    int          err_beat;
    int          flush_beat;
    bit          flush_addr;
    int          ar_delay;
    logic [31:0] seed;
    bit          early_drop;
  } txn_t;

  typedef struct {
    logic        port;
    logic [31:0] data;
  } fwd_t;

  typedef struct {
    logic port;
    bit   with_ar;
  } gnt_t;

  int total = 0;
  int bad   = 0;

  gnt_t        exp_grant[$];
  logic [39:0] exp_ar[$];
  fwd_t        exp_fwd[$];
  int          exp_err[$];
  txn_t        cfg_q[$];

  bit mon_en   = 1'b1;
  bit slv_en   = 1'b1;
  bit slv_busy = 1'b0;
  int hs_issued = 0;
  int hs_seen   = 0;
  int last_win  = 1;  // reference model: port 0 has priority after reset

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] beat_data(input logic [31:0] seed, input int j);
    return seed ^ (32'(j) * 32'h9E37_79B9);
  endfunction

  function automatic txn_t mk(input logic [31:0] a, input logic [7:0] l, input int n,
                              input int eb, input int fb, input bit fa, input int d);
    txn_t t;
    t.addr = a; t.len = l; t.nbeats = n; t.err_beat = eb; t.flush_beat = fb;
    t.flush_addr = fa; t.ar_delay = d; t.seed = a ^ 32'h5A5A_0000; t.early_drop = 1'b0;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.addr = $urandom();
    t.addr[1:0] = 2'b00;
    t.len = ($urandom_range(0, 6) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
    t.nbeats = int'(t.len);
    if (t.len != 0 && $urandom_range(0, 4) == 0) t.nbeats = int'($urandom_range(1, int'(t.len) + 3));
    t.err_beat   = (t.nbeats > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, t.nbeats)) : 0;
    t.flush_beat = (t.nbeats > 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, t.nbeats)) : 0;
    t.flush_addr = ($urandom_range(0, 7) == 0);
    t.ar_delay   = int'($urandom_range(0, 3));
    t.seed       = $urandom();
    t.early_drop = ($urandom_range(0, 3) == 0);
    return t;
  endfunction

  // Expected consequences of one granted request, in grant order.
  task automatic expect_txn(input int port, input txn_t t);
    gnt_t g;
    fwd_t f;
    g.port = port[0];
    g.with_ar = (t.len != 0);
    exp_grant.push_back(g);
    if (t.len != 0) begin
      exp_ar.push_back({t.addr, t.len - 8'd1});
      cfg_q.push_back(t);
      for (int j = 1; j <= t.nbeats; j++) begin
        hs_issued++;
        if (!t.flush_addr && (t.flush_beat == 0 || j < t.flush_beat)) begin
          f.port = port[0];
          f.data = beat_data(t.seed, j);
          exp_fwd.push_back(f);
        end
        if (j == t.err_beat || (j == t.nbeats && t.nbeats != int'(t.len)))
          exp_err.push_back(hs_issued);
      end
    end
  endtask

  task automatic issue(input logic [1:0] mask, input txn_t t0, input txn_t t1, input bit flush_idle);
    logic [1:0] rem, got;
    int g, n;
    bit seen_ar;
    rem = mask;
    while (rem != 2'b00) begin
      g = (rem[1 - last_win]) ? 1 - last_win : last_win;
      if (g == 0) expect_txn(0, t0); else expect_txn(1, t1);
      rem[g] = 1'b0;
      last_win = g;
    end
    @(posedge clk); #1;
    bus.req_addr_i[0] = t0.addr; bus.req_len_i[0] = t0.len;
    bus.req_addr_i[1] = t1.addr; bus.req_len_i[1] = t1.len;
    bus.req_valid_i = mask;
    flush_drv = flush_idle;
    got = 2'b00;
    n = 0;
    while (got != mask && n < 4000) begin
      @(negedge clk);
      got |= bus.req_ready_o;
      seen_ar = bus.arvalid_o;
      @(posedge clk); #1;
      flush_drv = 1'b0;
      bus.req_valid_i &= ~got;
      if (seen_ar && ((mask == 2'b01 && t0.early_drop) || (mask == 2'b10 && t1.early_drop)))
        bus.req_valid_i = 2'b00;
      n++;
    end
    chk("all_granted", got, mask);
    bus.req_valid_i = 2'b00;
    n = 0;
    while ((cfg_q.size() != 0 || slv_busy) && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("burst_done", cfg_q.size() + int'(slv_busy), 0);
  endtask

  // AXI slave model: serves each predicted burst in order.
  initial begin : slave
    txn_t c;
    bus.arready_i = 1'b0;
    bus.rvalid_i  = 1'b0;
    bus.rdata_i   = '0;
    bus.rresp_i   = 2'b00;
    bus.rlast_i   = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (slv_en && bus.arvalid_o) begin
        if (cfg_q.size() == 0) begin
          $display("FAIL unexpected_ar: got arvalid with no request outstanding");
          $fatal(1);
        end
        c = cfg_q.pop_front();
        slv_busy = 1'b1;
        repeat (c.ar_delay) begin @(posedge clk); #1; end
        bus.arready_i = 1'b1;
        flush_slv = c.flush_addr;
        @(posedge clk); #1;
        bus.arready_i = 1'b0;
        flush_slv = 1'b0;
        for (int j = 1; j <= c.nbeats; j++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          bus.rvalid_i = 1'b1;
          bus.rdata_i  = beat_data(c.seed, j);
          bus.rresp_i  = (j == c.err_beat) ? 2'b10 : {1'b0, 1'($urandom_range(0, 1))};
          bus.rlast_i  = (j == c.nbeats);
          flush_slv    = (j == c.flush_beat);
          @(posedge clk); #1;
          bus.rvalid_i = 1'b0;
          bus.rlast_i  = 1'b0;
          bus.rresp_i  = 2'b00;
          flush_slv    = 1'b0;
        end
        slv_busy = 1'b0;
      end
    end
  end

  initial begin : monitor
    gnt_t g;
    fwd_t f;
    logic [39:0] a;
    int e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.rvalid_i && bus.rready_o) hs_seen++;
        if (bus.req_ready_o != 2'b00) begin
          if (exp_grant.size() == 0) chk("spurious_ready", bus.req_ready_o, 0);
          else begin
            g = exp_grant.pop_front();
            chk("grant_port", bus.req_ready_o, 2'b01 << g.port);
            chk("ready_with_ar", bus.arvalid_o & bus.arready_i, g.with_ar);
          end
        end
        if (bus.arvalid_o && bus.arready_i) begin
          if (exp_ar.size() == 0) chk("spurious_ar", 1, 0);
          else begin
            a = exp_ar.pop_front();
            chk("ar_addr_len", {bus.araddr_o, bus.arlen_o}, a);
            chk("ar_size_burst", {bus.arsize_o, bus.arburst_o}, 5'b010_01);
          end
        end
        if (bus.req_data_valid_o != 2'b00) begin
          if (exp_fwd.size() == 0) chk("spurious_data", bus.req_data_valid_o, 0);
          else begin
            f = exp_fwd.pop_front();
            chk("fwd_port", bus.req_data_valid_o, 2'b01 << f.port);
            chk("fwd_data", bus.req_data_o, f.data);
          end
        end
        if (bus.bus_err_o) begin
          if (exp_err.size() == 0) chk("spurious_err", 1, 0);
          else begin
            e = exp_err.pop_front();
            chk("err_beat", hs_seen, e);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  initial begin : driver
    txn_t t0, t1, z;
    int n;
    bus.req_valid_i = '0;
    bus.req_addr_i  = '0;
    bus.req_len_i   = '0;
    z = mk(32'h0, 8'd0, 0, 0, 0, 1'b0, 0);

    mon_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {bus.arvalid_o, bus.rready_o, bus.req_ready_o, bus.req_data_valid_o, bus.bus_err_o}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // icache len 8, arready on the 2nd ADDR cycle
    issue(2'b01, mk(32'h1C00_0020, 8'd8, 8, 0, 0, 1'b0, 1), z, 1'b0);
    // both ports together, twice
    issue(2'b11, mk(32'h0000_1000, 8'd3, 3, 0, 0, 1'b0, 0), mk(32'h0000_2000, 8'd2, 2, 0, 0, 1'b0, 2), 1'b0);
    issue(2'b11, mk(32'h0000_3000, 8'd1, 1, 0, 0, 1'b0, 0), mk(32'h0000_4000, 8'd4, 4, 0, 0, 1'b0, 0), 1'b0);
    // dcache len 0
    issue(2'b10, z, mk(32'h0000_5000, 8'd0, 0, 0, 0, 1'b0, 0), 1'b0);
    // flush on beat 3, error on beat 2 with early rlast, flush during ADDR
    issue(2'b01, mk(32'h0000_6000, 8'd8, 8, 0, 3, 1'b0, 0), z, 1'b0);
    issue(2'b10, z, mk(32'h0000_7000, 8'd8, 6, 2, 0, 1'b0, 0), 1'b0);
    issue(2'b01, mk(32'h0000_8000, 8'd4, 4, 0, 0, 1'b1, 2), z, 1'b0);
    // flush in IDLE delays the grant; maximum length; overrun past len
    issue(2'b11, mk(32'h0000_9000, 8'd2, 2, 0, 0, 1'b0, 0), mk(32'h0000_A000, 8'd0, 0, 0, 0, 1'b0, 0), 1'b1);
    issue(2'b10, z, mk(32'h0001_0000, 8'd255, 255, 0, 0, 1'b0, 0), 1'b0);
    issue(2'b01, mk(32'h0000_B000, 8'd2, 4, 0, 0, 1'b0, 0), z, 1'b0);

    for (int k = 0; k < 40; k++) begin
      t0 = rand_txn();
      t1 = rand_txn();
      issue(2'($urandom_range(1, 3)), t0, t1, ($urandom_range(0, 3) == 0));
    end

    repeat (4) @(posedge clk);
    chk("grants_left", exp_grant.size(), 0);
    chk("ar_left", exp_ar.size(), 0);
    chk("fwd_left", exp_fwd.size(), 0);
    chk("err_left", exp_err.size(), 0);
    chk("beats_seen", hs_seen, hs_issued);

    // Reset in the middle of a burst, then check the pointer restarted at port 0.
    mon_en = 1'b0;
    slv_en = 1'b0;
    @(posedge clk); #1;
    bus.req_addr_i[0] = 32'h0000_C000;
    bus.req_len_i[0]  = 8'd8;
    bus.req_valid_i   = 2'b01;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.arvalid_o && n < 20);
    chk("rst_ar_seen", bus.arvalid_o, 1);
    @(posedge clk); #1;
    bus.arready_i = 1'b1;
    @(posedge clk); #1;
    bus.arready_i = 1'b0;
    bus.req_valid_i = 2'b00;
    bus.rvalid_i = 1'b1;
    bus.rdata_i  = 32'hDEAD_0001;
    @(posedge clk); #1;
    bus.rdata_i = 32'hDEAD_0002;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_outputs", {bus.arvalid_o, bus.rready_o, bus.req_ready_o, bus.req_data_valid_o, bus.bus_err_o}, 0);
    @(posedge clk); #1;
    bus.rvalid_i = 1'b0;
    bus.req_len_i = '0;
    bus.req_valid_i = 2'b11;
    @(negedge clk);
    chk("post_rst_grant0", bus.req_ready_o, 2'b01);
    chk("len0_no_ar", bus.arvalid_o, 0);
    @(posedge clk); #1;
    bus.req_valid_i = 2'b10;
    @(negedge clk);
    chk("post_rst_grant1", bus.req_ready_o, 2'b10);
    @(posedge clk); #1;
    bus.req_valid_i = 2'b00;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
